// File: rtl/magnitude_tracker.sv
// Sliding-window magnitude average with peak hold and a debounced, hysteretic alarm.
// One-cycle latency, no backpressure; optional peak logic enabled by MAGTRK_PEAK_EN.
module magnitude_tracker #(
  parameter int WIN_LOG2 = 3,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mag_in,
  input  logic              mag_valid,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic              clear_peak,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              win_full,
  output logic [DATA_W-1:0] peak_out,
  output logic              alarm
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_W + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_MAX = (WIN_LOG2+1)'(DEPTH);
  localparam logic [WIN_LOG2:0] FILL_PRE = (WIN_LOG2+1)'(DEPTH - 1);

  typedef enum logic [1:0] {QUIET, PENDING, ALERT} state_t;

  logic [DATA_W-1:0]   win_buf [DEPTH];
  logic [WIN_LOG2-1:0] wp;
  logic [WIN_LOG2:0]   fill_cnt;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [DATA_W-1:0]   avg_next;
  logic                full_incl;
  state_t              state_q, state_d;

  assign sum_next  = sum + SUM_W'(mag_in) - SUM_W'(win_buf[wp]);
  assign avg_next  = sum_next[SUM_W-1:WIN_LOG2];
  // True when the sample being accepted completes (or follows) a full window.
  assign full_incl = (fill_cnt >= FILL_PRE);
  assign win_full  = fill_cnt[WIN_LOG2];
  assign alarm     = (state_q == ALERT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win_buf[i] <= '0;
      wp        <= '0;
      fill_cnt  <= '0;
      sum       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= mag_valid && full_incl;
      if (mag_valid) begin
        win_buf[wp] <= mag_in;
        wp          <= wp + 1'b1;
        sum         <= sum_next;
        avg_out     <= avg_next;
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= QUIET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mag_valid && full_incl) begin
      case (state_q)
        QUIET:   if (avg_next >= thr_hi) state_d = PENDING;
        PENDING: state_d = (avg_next >= thr_hi) ? ALERT : QUIET;
        ALERT:   if (avg_next < thr_lo) state_d = QUIET;
        default: state_d = QUIET;
      endcase
    end
  end

`ifdef MAGTRK_PEAK_EN
  logic [DATA_W-1:0] peak_q;

  // A clear that coincides with a sample restarts tracking from that sample.
  always_ff @(posedge clk) begin
    if (rst)                                peak_q <= '0;
    else if (clear_peak && mag_valid)       peak_q <= mag_in;
    else if (clear_peak)                    peak_q <= '0;
    else if (mag_valid && mag_in > peak_q)  peak_q <= mag_in;
  end

  assign peak_out = peak_q;
`else
  logic unused_clear_peak;
  assign unused_clear_peak = clear_peak;
  assign peak_out = '0;
`endif

endmodule

// File: tb/tb_magnitude_tracker.sv
// Randomized and directed bench for magnitude_tracker against a queue-based reference model.
module tb_magnitude_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mag_in = '0;
  logic       mag_valid = 1'b0;
  logic [7:0] thr_hi = 8'd100;
  logic [7:0] thr_lo = 8'd50;
  logic       clear_peak = 1'b0;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       win_full;
  logic [7:0] peak_out;
  logic       alarm;

  int errors = 0;
  int checks = 0;

  // Reference model state: recent samples, count since reset, and expected outputs.
  int win_q[$];
  int n_acc;
  int m_avg, m_vld, m_full, m_peak, m_alarm, m_armed;

  magnitude_tracker #(.WIN_LOG2(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .mag_in(mag_in), .mag_valid(mag_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear_peak(clear_peak),
    .avg_out(avg_out), .avg_valid(avg_valid), .win_full(win_full),
    .peak_out(peak_out), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    n_acc = 0;
    m_avg = 0; m_vld = 0; m_full = 0; m_peak = 0; m_alarm = 0; m_armed = 0;
  endtask

  task automatic model_update(input int v, input int m, input int c, input int r,
                              input int hi, input int lo);
    int s;
    if (r != 0) begin
      model_reset();
      return;
    end
`ifdef MAGTRK_PEAK_EN
    if (c != 0) m_peak = (v != 0) ? m : 0;
    else if (v != 0 && m > m_peak) m_peak = m;
`endif
    if (v == 0) begin
      m_vld = 0;
      return;
    end
    win_q.push_back(m);
    if (win_q.size() > 8) void'(win_q.pop_front());
    if (n_acc < 8) n_acc++;
    s = 0;
    foreach (win_q[i]) s += win_q[i];
    m_avg  = s / 8;
    m_full = (n_acc == 8) ? 1 : 0;
    m_vld  = m_full;
    if (m_vld != 0) begin
      // Two consecutive qualifying averages are needed to enter the alarm.
      if (m_alarm != 0) begin
        if (m_avg < lo) m_alarm = 0;
      end else if (m_avg >= hi) begin
        if (m_armed != 0) begin m_alarm = 1; m_armed = 0; end
        else m_armed = 1;
      end else begin
        m_armed = 0;
      end
    end
  endtask

  task automatic step(input int v, input int m, input int c, input int r);
    mag_valid  = (v != 0);
    mag_in     = 8'(m);
    clear_peak = (c != 0);
    rst        = (r != 0);
    @(posedge clk);
    model_update(v, m, c, r, int'(thr_hi), int'(thr_lo));
    #1;
    check("avg_out",   int'(avg_out),   m_avg);
    check("avg_valid", int'(avg_valid), m_vld);
    check("win_full",  int'(win_full),  m_full);
    check("peak_out",  int'(peak_out),  m_peak);
    check("alarm",     int'(alarm),     m_alarm);
  endtask

  initial begin
    model_reset();
    // Reset with random inputs present.
    for (int i = 0; i < 2; i++)
      step($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1), 1);

    thr_hi = 8'd100;
    thr_lo = 8'd50;
    for (int i = 0; i < 8; i++)  step(1, 40, 0, 0);
    check("avg_after_fill", int'(avg_out), 40);
    for (int i = 0; i < 8; i++)  step(1, 200, 0, 0);
    check("alarm_after_200s", int'(alarm), 1);
    for (int i = 0; i < 8; i++)  step(1, 0, 0, 0);
    check("alarm_cleared", int'(alarm), 0);

    step(0, 0, 0, 0);
    step(1, 10, 0, 0);
    step(1, 250, 0, 0);
    step(1, 30, 0, 0);
    step(0, 0, 0, 0);
    step(1, 7, 1, 0);
    step(0, 0, 0, 0);
    step(0, 99, 1, 0);

    for (int i = 0; i < 5; i++)  step(1, 90, 0, 0);
    step(1, 90, 1, 1);
    for (int i = 0; i < 7; i++)  step(1, 16, 0, 0);
    check("no_valid_before_8", int'(avg_valid), 0);
    step(1, 16, 0, 0);
    check("valid_at_8", int'(avg_valid), 1);
    check("avg_at_8", int'(avg_out), 16);

    // Random traffic with gaps, live threshold changes, clears and sparse resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        thr_hi = 8'($urandom_range(0, 255));
        thr_lo = 8'($urandom_range(0, 255));
      end
      step(($urandom_range(0, 9) < 7) ? 1 : 0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(150, 255),
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 99) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/magnitude_tracker.md
# magnitude_tracker

Downstream post-processing stage for the vector-magnitude engine. Consumes the 8-bit magnitude stream and keeps a sliding-window average in a circular sample buffer. Tracks the peak magnitude and raises a debounced, hysteretic alarm when the average crosses programmable thresholds. Sits between the magnitude output and the chip's status outputs.

## Interface
- `WIN_LOG2`, default 3: log2 of the averaging window depth (window = 2^WIN_LOG2 samples; legal range 1..6).
- `DATA_W`, default 8: magnitude width.
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `mag_in`  input  DATA_W  magnitude sample.
- `mag_valid`  input  1  `mag_in` is accepted on every edge where this is high. No backpressure.
- `thr_hi`  input  DATA_W  alarm entry threshold.
- `thr_lo`  input  DATA_W  alarm exit threshold.
- `clear_peak`  input  1  restarts peak tracking.
- `avg_out`  output  DATA_W  window sum >> WIN_LOG2 (floor).
- `avg_valid`  output  1  one-cycle pulse when `avg_out` holds a full-window average.
- `win_full`  output  1  the window has held 2^WIN_LOG2 samples since reset.
- `peak_out`  output  DATA_W  maximum accepted sample since reset or last clear.
- `alarm`  output  1  high while the FSM is in ALERT.

## Operation
- Buffer: 2^WIN_LOG2 × DATA_W registers with a write pointer `wp` (WIN_LOG2 bits). Wrap-around is natural overflow.
- On an accepted sample:
  - `sum_next = sum + mag_in - buf[wp]`
  - `buf[wp] <= mag_in`
  - `wp <= wp+1`
  - `sum <= sum_next`
  - `avg_out <= sum_next >> WIN_LOG2`
- `sum` is DATA_W+WIN_LOG2 bits wide and unsigned. It cannot overflow, because the buffer is zeroed on reset. Partial-window averages still update `avg_out`.
- Fill counter saturates at 2^WIN_LOG2. `win_full` is registered high on the edge that accepts the 2^WIN_LOG2-th sample.
- `avg_valid` is registered as (accepted sample AND window full including this sample). It is 0 in every cycle without an accepted sample.
- Alarm FSM is evaluated only on edges that assert `avg_valid`, using `a = sum_next >> WIN_LOG2`. It holds otherwise.
  - QUIET: `a >= thr_hi` → PENDING, else stay.
  - PENDING: `a >= thr_hi` → ALERT, else → QUIET.
  - ALERT: `a < thr_lo` → QUIET, else stay.
  - `alarm` = (state == ALERT), registered.
- Thresholds are sampled live and are not checked. If `thr_lo > thr_hi`, the FSM still follows the rules above.
- Peak:
  - An accepted sample with `mag_in > peak` sets `peak <= mag_in`.
  - `clear_peak` alone sets `peak <= 0`.
  - `clear_peak` together with an accepted sample sets `peak <= mag_in`.
- Reset clears buffer, `sum`, `wp`, fill counter, FSM (→QUIET) and all outputs. Reset overrides `mag_valid` and `clear_peak` in the same cycle. A mid-stream reset discards the window, and filling restarts from zero.

## Timing
- Reset values: `avg_out`=0, `avg_valid`=0, `win_full`=0, `peak_out`=0, `alarm`=0.
- Latency is one cycle. A sample accepted at edge t is reflected in `avg_out`, `avg_valid`, `win_full` and `peak_out` in the cycle after edge t.
- `alarm` changes on the same edge that asserts the `avg_valid` that caused the transition.
- Back-to-back samples (`mag_valid` held high) are supported at full rate. Gaps of any length are allowed.
- The buffer read of `buf[wp]` and the write to it occur at the same edge; the read returns the old value.

## Configuration
- `MAGTRK_PEAK_EN` defined: the peak register and its logic are compiled in, as described above.
- `MAGTRK_PEAK_EN` undefined: no peak register. `peak_out` is tied to 0 and `clear_peak` is ignored. All other behaviour is unchanged.

## Test plan
All scenarios use WIN_LOG2=3, DATA_W=8, `MAGTRK_PEAK_EN` defined.
- Assert `rst` for 2 cycles with random inputs → all outputs 0. After release, no `avg_valid` until 8 samples.
- Feed 8 samples of 40 → `avg_out` reads 5, 10, …, 40. `avg_valid` and `win_full` first go high after the 8th sample, with `avg_out`=40.
- Continue with 8 samples of 200 → `avg_out` = 60, 80, 100, 120, 140, 160, 180, 200, each with an `avg_valid` pulse.
- `thr_hi`=100, `thr_lo`=50 during the previous step → FSM reaches PENDING at avg 100 and `alarm`=1 at avg 120. Then feed 8 zeros → averages 175 … 50 keep `alarm`=1, 25 clears it.
- Samples 10, 250, 30 → `peak_out`=250. Then `clear_peak` with `mag_in`=7 accepted → `peak_out`=7. Then `clear_peak` alone → 0.
- After 5 samples of 90, pulse `rst` → all outputs 0. Then 7 samples of 16 give no `avg_valid`. The 8th gives `avg_valid`=1 with `avg_out`=16.
